// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory port, decode-facing stream with
// valid/ready handshake, and the branch redirect request.
interface fetch_sequencer_if;
    logic [63:0] inst_addr;
    logic [31:0] inst_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // Fetch controller side.
    modport master (
        output inst_addr,
        input  inst_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        input  redirect_valid,
        input  redirect_pc
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  inst_addr,
        output inst_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle from a
// combinational instruction memory and buffers {pc, inst} pairs in a 2-entry
// in-order queue toward decode. Handles redirects with flush, end-of-image
// drain, and a sticky trap on misaligned redirect targets.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 152
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FAULT
    } state_t;

    localparam logic [64:0] IMAGE_END = 65'(IMEM_BYTES);

    state_t      state;
    state_t      next_state;
    logic [63:0] pc;
    logic [1:0]  count;
    logic [1:0]  count_after_pop;
    logic [1:0]  next_count;
    logic [63:0] q_pc   [2];
    logic [31:0] q_inst [2];

    logic [64:0] fetch_end;
    logic        legal;
    logic        redirect;
    logic        pop;
    logic        push;

    assign bus.inst_addr = pc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_pc    = q_pc[0];
    assign bus.out_inst  = q_inst[0];

    // Fetch legality, handshake qualification and next occupancy/state.
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fetch_end       = {1'b0, pc} + 65'd4;   // 65-bit so a wrapped pc+4 never looks in range
        legal           = (fetch_end <= IMAGE_END);
        redirect        = bus.redirect_valid && (state != FAULT);
        pop             = (count != 2'd0) && bus.out_ready && !redirect;
        push            = (state == RUN) && !redirect && legal && ((count != 2'd2) || pop);
        count_after_pop = count - {1'b0, pop};
        next_count      = count_after_pop + {1'b0, push};
        next_state      = state;
        if (state == RUN && !legal) begin
            next_state = DRAIN;
        end
    end

    // Sequential state: PC, queue storage, FSM, counters and registered status.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            count       <= 2'd0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
            // NOTE: queue storage is reset only because out_pc/out_inst have defined reset values.
            for (int i = 0; i < 2; i++) begin
                q_pc[i]   <= 64'd0;
                q_inst[i] <= 32'd0;
            end
        end else if (redirect) begin
            // Redirect wins over everything: flush, drop any pop, no push.
            count  <= 2'd0;
            halted <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state <= FAULT;
                fault <= 1'b1;
            end else begin
                pc    <= bus.redirect_pc;
                state <= RUN;
            end
        end else begin
            if (pop) begin
                q_pc[0]   <= q_pc[1];
                q_inst[0] <= q_inst[1];
                if (fetch_count != 32'hFFFF_FFFF) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
            // A push after a shift lands in the slot just behind the surviving entries.
            if (push) begin
                q_pc[count_after_pop[0]]   <= pc;
                q_inst[count_after_pop[0]] <= bus.inst_data;
                pc                         <= pc + 64'd4;
            end
            count  <= next_count;
            state  <= next_state;
            halted <= (next_state == DRAIN) && (next_count == 2'd0);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized phase. A negedge monitor keeps a stream-level model (the list of
// pcs still owed to decode) and checks every handshake against it.
module tb_fetch_sequencer;

    localparam int unsigned IMEM_BYTES = 152;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC   (64'd0),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction image and combinational read port.
    logic [31:0] mem [64];

    always_comb begin
        if (bus.inst_addr < 64'(IMEM_BYTES)) begin
            bus.inst_data = mem[bus.inst_addr[7:2]];
        end else begin
            bus.inst_data = 32'hDEAD_BEEF;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Reference model (monitor-owned) ----------------
    // The design owes decode every word address from the last restart point up
    // to the end of the image, in order; a redirect discards whatever is owed
    // and restarts the list, a misaligned one empties it for good.
    logic [63:0] exp_q[$];
    int unsigned model_count = 0;
    bit          model_fault = 1'b0;

    function automatic void load_stream(input logic [63:0] start);
        exp_q.delete();
        for (longint unsigned a = start; a + 4 <= IMEM_BYTES; a += 4) begin
            exp_q.push_back(64'(a));
        end
    endfunction

    always @(negedge clk) begin
        logic [63:0] exp_pc;
        if (!reset) begin
            load_stream(64'd0);
            model_count = 0;
            model_fault = 1'b0;
        end else begin
            check("mon_fetch_count", 64'(fetch_count), 64'(model_count));
            check("mon_fault", 64'(fault), 64'(model_fault));
            if (exp_q.size() == 0) begin
                check("mon_idle_out_valid", 64'(bus.out_valid), 64'd0);
            end
            if (halted) begin
                check("mon_halted_with_work_owed", 64'(exp_q.size()), 64'd0);
            end
            if (bus.redirect_valid && !model_fault) begin
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    model_fault = 1'b1;
                    exp_q.delete();
                end else begin
                    load_stream(bus.redirect_pc);
                end
            end else if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_handshake", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("mon_out_pc", bus.out_pc, exp_pc);
                    check("mon_out_inst", 64'(bus.out_inst), 64'(mem[exp_pc[7:2]]));
                    model_count++;
                end
            end
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;

        // Reset state.
        step();
        step();
        check("rst_inst_addr", bus.inst_addr, 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_pc", bus.out_pc, 64'd0);
        check("rst_out_inst", 64'(bus.out_inst), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_fetch_count", 64'(fetch_count), 64'd0);

        // Straight-line run with out_ready high: one word per cycle.
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 38; k++) begin
            step();
            check("line_out_valid", 64'(bus.out_valid), 64'd1);
            check("line_out_pc", bus.out_pc, 64'(4 * k));
            check("line_out_inst", 64'(bus.out_inst), 64'(mem[k]));
            check("line_halted", 64'(halted), 64'd0);
        end
        step();
        check("line_halted_end", 64'(halted), 64'd1);
        check("line_out_valid_end", 64'(bus.out_valid), 64'd0);
        check("line_fetch_count", 64'(fetch_count), 64'd38);

        // Backpressure: ready low for 5 cycles, queue fills, pc held at 8.
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.out_ready = 1'b0;
        step();
        step();
        check("bp_inst_addr_full", bus.inst_addr, 64'd8);
        check("bp_head_pc", bus.out_pc, 64'd0);
        step();
        step();
        step();
        check("bp_inst_addr_held", bus.inst_addr, 64'd8);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_second_pc", bus.out_pc, 64'd4);
        check("bp_inst_addr_resume", bus.inst_addr, 64'd12);
        step();
        check("bp_third_pc", bus.out_pc, 64'd8);
        check("bp_fetch_count", 64'(fetch_count), 64'd2);

        // Redirect to 0x24 while queue holds 8 and 12, with a same-cycle ready.
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        step();
        check("rd_head_pc", bus.out_pc, 64'd8);
        check("rd_inst_addr", bus.inst_addr, 64'd16);
        check("rd_fetch_count_before", 64'(fetch_count), 64'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h24;
        bus.out_ready      = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("rd_flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("rd_fetch_count_after", 64'(fetch_count), 64'd2);
        step();
        check("rd_target_valid", 64'(bus.out_valid), 64'd1);
        check("rd_target_pc", bus.out_pc, 64'h24);
        check("rd_target_inst", 64'(bus.out_inst), 64'(mem[9]));

        // Misaligned redirect to 0x22: sticky fault, pc frozen at 0x28.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h22;
        step();
        bus.redirect_valid = 1'b0;
        check("flt_fault", 64'(fault), 64'd1);
        check("flt_out_valid", 64'(bus.out_valid), 64'd0);
        check("flt_inst_addr", bus.inst_addr, 64'h28);
        check("flt_fetch_count", 64'(fetch_count), 64'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h10;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("flt_sticky", 64'(fault), 64'd1);
        check("flt_sticky_out_valid", 64'(bus.out_valid), 64'd0);
        check("flt_pc_frozen", bus.inst_addr, 64'h28);
        reset = 1'b0;
        step();
        check("flt_reset_fault", 64'(fault), 64'd0);
        check("flt_reset_inst_addr", bus.inst_addr, 64'd0);
        check("flt_reset_fetch_count", 64'(fetch_count), 64'd0);

        // Redirect to 200 (out of image): drain then halt; redirect to 0 resumes.
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'd200;
        step();
        bus.redirect_valid = 1'b0;
        check("oor_out_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 4 && !halted; i++) step();
        check("oor_halted", 64'(halted), 64'd1);
        check("oor_inst_addr", bus.inst_addr, 64'd200);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'd0;
        step();
        bus.redirect_valid = 1'b0;
        check("oor_resume_halted", 64'(halted), 64'd0);
        step();
        check("oor_resume_valid", 64'(bus.out_valid), 64'd1);
        check("oor_resume_pc", bus.out_pc, 64'd0);
        check("oor_resume_halted2", 64'(halted), 64'd0);

        // Reset asserted while the queue is full and stalled.
        bus.out_ready = 1'b0;
        step();
        step();
        check("frst_full_valid", 64'(bus.out_valid), 64'd1);
        check("frst_stalled_addr", bus.inst_addr, 64'd8);
        check("frst_count_before", 64'(fetch_count), 64'd2);
        reset = 1'b0;
        step();
        check("frst_out_valid", 64'(bus.out_valid), 64'd0);
        check("frst_inst_addr", bus.inst_addr, 64'd0);
        check("frst_fetch_count", 64'(fetch_count), 64'd0);

        // Randomized phase: checked entirely by the monitor.
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.redirect_pc = 64'(4 * $urandom_range(0, 40) + $urandom_range(1, 3));
            end else begin
                bus.redirect_pc = 64'(4 * $urandom_range(0, 50));
            end
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        bus.redirect_valid = 1'b0;
        reset = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
